// File: rtl/mem_arbiter_pkg.sv
// Shared types for the icache/dcache RAM port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arbiter_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
   typedef enum logic [1:0] {IDLE, DACC, IACC} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side and RAM-side signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: iwait/dwait stall the caches; ramstate paces the RAM side.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      iwait;
   word_t     iload;
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      dwait;
   word_t     dload;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;
   logic      err;

   // Arbiter side.
   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );

   // Caches plus RAM side.
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/mem_arbiter_timeout.sv
// Cycle counter for a granted access; flags expiry at TIMEOUT-1.
// Latency: expire is combinational from the registered count.
// Backpressure: none; clr has priority over en.
module arb_timeout_counter #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [W-1:0] tmo_cnt;

   // Count cycles spent in an access; held at zero while cleared.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         tmo_cnt <= '0;
      end else if (en && !expire) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign expire = (tmo_cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache (read) and dcache (read/write), dcache first.
// Latency: 1-cycle grant from IDLE; completion visible in the ACCESS cycle.
// Backpressure: iwait/dwait held high until ramstate==ACCESS; one IDLE bubble between grants.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 64
) (
   input logic        CLK,
   input logic        RST,
   mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_t    state;
   logic [SW-1:0] starve_cnt;
   logic          dreq;
   logic          complete;
   logic          withdraw;
   logic          abort;
   logic          leave;
   logic          expire;
   logic          tmo_clr;
   logic          ram_ren;
   logic          ram_wen;
   word_t         ram_addr;
   word_t         ram_store;

   // Access outcome for the current cycle; completion beats withdrawal beats abort.
   always_comb begin
      dreq     = bus.dREN | bus.dWEN;
      complete = (state != IDLE) && (bus.ramstate == ACCESS);
      withdraw = ((state == DACC) && !dreq) || ((state == IACC) && !bus.iREN);
      abort    = (state != IDLE) && !complete && !withdraw &&
                 ((bus.ramstate == ERROR) || expire);
      leave    = complete | withdraw | abort;
      tmo_clr  = (state == IDLE) || leave;
   end

   arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk    (CLK),
      .rst    (RST),
      .clr    (tmo_clr),
      .en     (state != IDLE),
      .expire (expire)
   );

   // RAM port steering: the granted cache drives the port, writes win over reads.
   always_comb begin
      ram_ren   = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = '0;
      ram_store = '0;
      case (state)
         DACC: begin
            ram_ren   = bus.dREN & ~bus.dWEN;
            ram_wen   = bus.dWEN;
            ram_addr  = bus.daddr;
            ram_store = bus.dstore;
         end
         IACC: begin
            ram_ren  = 1'b1;
            ram_addr = bus.iaddr;
         end
         default: ;
      endcase
   end

   assign bus.ramREN   = ram_ren;
   assign bus.ramWEN   = ram_wen;
   assign bus.ramaddr  = ram_addr;
   assign bus.ramstore = ram_store;
   assign bus.iwait    = !((state == IACC) && complete);
   assign bus.dwait    = !((state == DACC) && complete);
   assign bus.iload    = bus.ramload;
   assign bus.dload    = bus.ramload;
   assign bus.err      = abort;

   // Grant FSM with the icache anti-starvation counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.iREN) begin
                  starve_cnt <= '0;
               end
               if (dreq && !(bus.iREN && (starve_cnt == SW'(STARVE_LIMIT)))) begin
                  state <= DACC;
               end else if (bus.iREN) begin
                  state <= IACC;
               end
            end
            DACC: begin
               if (complete && bus.iREN && (starve_cnt != SW'(STARVE_LIMIT))) begin
                  starve_cnt <= starve_cnt + 1'b1;
               end
               if (leave) begin
                  state <= IDLE;
               end
            end
            IACC: begin
               if (complete) begin
                  starve_cnt <= '0;
               end
               if (leave) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a latency-programmable RAM model.
// Latency: checks 1-cycle grant and ACCESS-cycle completion.
// Backpressure: RAM model holds BUSY/ERROR to exercise stalls and aborts.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   typedef struct {
      bit    is_d;
      bit    wr;
      word_t addr;
      word_t data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ram_lat  = 1;
   int   ram_mode = 0;   // 0 normal, 1 stuck BUSY, 2 ERROR
   int   acc_cyc  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   function automatic word_t ram_data(input word_t a);
      return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hC0DE_0000);
   endfunction

   // RAM model: ACCESS on the ram_lat-th enabled cycle of an access.
   always @(posedge clk) begin
      #2;
      if (bus.ramREN || bus.ramWEN) begin
         acc_cyc = acc_cyc + 1;
         if (ram_mode == 2)                           bus.ramstate = ERROR;
         else if (ram_mode == 0 && acc_cyc == ram_lat) bus.ramstate = ACCESS;
         else                                          bus.ramstate = BUSY;
         bus.ramload = ram_data(bus.ramaddr);
      end else begin
         acc_cyc      = 0;
         bus.ramstate = FREE;
      end
   end

   // Scoreboard consumer: every wait drop must match the next expected access.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (bus.iwait === 1'b0 || bus.dwait === 1'b0)) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: unexpected completion iwait=%b dwait=%b", bus.iwait, bus.dwait);
         end else begin
            e = sb.pop_front();
            if ({bus.iwait, bus.dwait} !== {e.is_d, !e.is_d}) begin
               n_fail++;
               $display("FAIL sb_requester: iwait/dwait=%b%b expected %b%b", bus.iwait, bus.dwait, e.is_d, !e.is_d);
            end
            n_checks++;
            if (bus.ramaddr !== e.addr) begin
               n_fail++;
               $display("FAIL sb_addr: ramaddr=%h expected %h", bus.ramaddr, e.addr);
            end
            n_checks++;
            if (e.wr) begin
               if ({bus.ramWEN, bus.ramREN, bus.ramstore} !== {1'b1, 1'b0, e.data}) begin
                  n_fail++;
                  $display("FAIL sb_write: wen=%b ren=%b store=%h expected 1 0 %h", bus.ramWEN, bus.ramREN, bus.ramstore, e.data);
               end
            end else if ((e.is_d ? bus.dload : bus.iload) !== e.data || bus.ramREN !== 1'b1) begin
               n_fail++;
               $display("FAIL sb_read: load=%h ren=%b expected %h 1", e.is_d ? bus.dload : bus.iload, bus.ramREN, e.data);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit is_d, input int budget, output int cyc);
      cyc = 0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if ((is_d ? bus.dwait : bus.iwait) === 1'b0) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
      bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err} !== 5'b11000) begin
         n_fail++;
         $display("FAIL reset_ctrl: iw dw ren wen err=%b expected 11000",
                  {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err});
      end
      n_checks++;
      if ({bus.ramaddr, bus.ramstore} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_bus: ramaddr=%h ramstore=%h expected 0 0", bus.ramaddr, bus.ramstore);
      end
      tick;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err} !== 5'b11000) begin
         n_fail++;
         $display("FAIL idle_ctrl: iw dw ren wen err=%b expected 11000",
                  {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err});
      end
   endtask

   task automatic test_icache_read;
      int cyc;
      ram_lat = 3;
      tick;
      bus.iREN = 1; bus.iaddr = 32'h100;
      sb.push_back('{1'b0, 1'b0, 32'h100, 32'hDEADBEEF});
      @(negedge clk);
      n_checks++;
      if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
         n_fail++;
         $display("FAIL icache_grant_latency: ren=%b iwait=%b expected 0 1", bus.ramREN, bus.iwait);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.ramREN, bus.ramWEN, bus.ramaddr} !== {1'b1, 1'b0, 32'h100}) begin
         n_fail++;
         $display("FAIL icache_enable: ren=%b wen=%b addr=%h expected 1 0 00000100", bus.ramREN, bus.ramWEN, bus.ramaddr);
      end
      wait_done(1'b0, 10, cyc);
      n_checks++;
      if (cyc != 2) begin
         n_fail++;
         $display("FAIL icache_latency: done after %0d more cycles expected 2", cyc);
      end
      tick;
      bus.iREN = 0;
      @(negedge clk);
      n_checks++;
      if (bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) begin
         n_fail++;
         $display("FAIL icache_one_cycle: iwait=%b ren=%b expected 1 0", bus.iwait, bus.ramREN);
      end
   endtask

   task automatic test_contention;
      int cyc;
      ram_lat = 2;
      tick;
      bus.iREN = 1; bus.iaddr = 32'h300;
      bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h12345678;
      sb.push_back('{1'b1, 1'b1, 32'h200, 32'h12345678});
      sb.push_back('{1'b0, 1'b0, 32'h300, ram_data(32'h300)});
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore} !== {1'b1, 1'b0, 32'h200, 32'h12345678}) begin
         n_fail++;
         $display("FAIL contention_dfirst: wen=%b ren=%b addr=%h store=%h expected 1 0 00000200 12345678",
                  bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore);
      end
      wait_done(1'b1, 10, cyc);
      n_checks++;
      if (cyc != 1) begin
         n_fail++;
         $display("FAIL contention_dlat: %0d expected 1", cyc);
      end
      tick;
      bus.dWEN = 0;
      n_checks++;
      @(negedge clk);
      if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
         n_fail++;
         $display("FAIL contention_bubble: ren=%b wen=%b expected 0 0", bus.ramREN, bus.ramWEN);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.ramREN, bus.ramaddr, bus.ramstore} !== {1'b1, 32'h300, 32'h0}) begin
         n_fail++;
         $display("FAIL contention_ithen: ren=%b addr=%h store=%h expected 1 00000300 0", bus.ramREN, bus.ramaddr, bus.ramstore);
      end
      wait_done(1'b0, 10, cyc);
      n_checks++;
      if (cyc != 1) begin
         n_fail++;
         $display("FAIL contention_ilat: %0d expected 1", cyc);
      end
      tick;
      bus.iREN = 0;
   endtask

   task automatic test_starvation;
      int  dcount = 0;
      bit  idone  = 0;
      ram_lat = 1;
      tick;
      bus.dREN = 1; bus.daddr = 32'h400;
      bus.iREN = 1; bus.iaddr = 32'h500;
      for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 1'b0, 32'h400, ram_data(32'h400)});
      sb.push_back('{1'b0, 1'b0, 32'h500, ram_data(32'h500)});
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (bus.dwait === 1'b0) dcount++;
         if (bus.iwait === 1'b0) begin
            idone = 1;
            break;
         end
      end
      tick;
      bus.dREN = 0; bus.iREN = 0;
      n_checks++;
      if (!idone || dcount != 4) begin
         n_fail++;
         $display("FAIL starvation: dcache completions=%0d icache done=%0d expected 4 1", dcount, idone);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL starvation_drain: %0d left expected 0", sb.size());
      end
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int err_at = 0, err_cnt = 0;
      bit dlow = 0;
      logic ren10, ren11;
      ram_mode = 1;
      tick;
      bus.dREN = 1; bus.daddr = 32'h600;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (bus.err === 1'b1) begin
            err_cnt++;
            err_at = k;
         end
         if (bus.dwait === 1'b0) dlow = 1;
         if (k == 10) ren10 = bus.ramREN;
         if (k == 11) ren11 = bus.ramREN;
      end
      tick;
      bus.dREN = 0;
      ram_mode = 0;
      n_checks++;
      if (err_at != 9 || err_cnt != 1) begin
         n_fail++;
         $display("FAIL timeout_err: pulse at %0d count %0d expected 9 1", err_at, err_cnt);
      end
      n_checks++;
      if (dlow) begin
         n_fail++;
         $display("FAIL timeout_dwait: dwait dropped expected held 1");
      end
      n_checks++;
      if ({ren10, ren11} !== 2'b01) begin
         n_fail++;
         $display("FAIL timeout_regrant: ren bubble/regrant=%b expected 01", {ren10, ren11});
      end
      @(negedge clk);
      n_checks++;
      if (bus.err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_withdraw_err: err=%b expected 0", bus.err);
      end
      @(negedge clk);
   endtask

   task automatic test_error;
      ram_mode = 2;
      tick;
      bus.iREN = 1; bus.iaddr = 32'h700;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.err, bus.iwait, bus.ramREN} !== 3'b111) begin
         n_fail++;
         $display("FAIL error_pulse: err iwait ren=%b expected 111", {bus.err, bus.iwait, bus.ramREN});
      end
      tick;
      bus.iREN = 0;
      ram_mode = 0;
      @(negedge clk);
      n_checks++;
      if ({bus.err, bus.ramREN} !== 2'b00) begin
         n_fail++;
         $display("FAIL error_abort: err ren=%b expected 00", {bus.err, bus.ramREN});
      end
   endtask

   task automatic test_mid_reset;
      ram_lat = 6;
      tick;
      bus.iREN = 1; bus.iaddr = 32'h800;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.ramREN !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre: ren=%b expected 1", bus.ramREN);
      end
      tick;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.ramREN, bus.iwait, bus.err, bus.ramaddr} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL midrst_idle: ren=%b iwait=%b err=%b addr=%h expected 0 1 0 0",
                  bus.ramREN, bus.iwait, bus.err, bus.ramaddr);
      end
      tick;
      rst = 1'b0;
      bus.iREN = 0;
      @(negedge clk);
   endtask

   task automatic test_withdraw;
      int cyc;
      ram_lat = 5;
      tick;
      bus.dREN = 1; bus.daddr = 32'h900;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.ramREN, bus.ramaddr} !== {1'b1, 32'h900}) begin
         n_fail++;
         $display("FAIL withdraw_pre: ren=%b addr=%h expected 1 00000900", bus.ramREN, bus.ramaddr);
      end
      tick;
      bus.dREN = 0;
      bus.iREN = 1; bus.iaddr = 32'hA00;
      sb.push_back('{1'b0, 1'b0, 32'hA00, ram_data(32'hA00)});
      @(negedge clk);
      n_checks++;
      if ({bus.err, bus.dwait} !== 2'b01) begin
         n_fail++;
         $display("FAIL withdraw_quiet: err dwait=%b expected 01", {bus.err, bus.dwait});
      end
      @(negedge clk);
      n_checks++;
      if ({bus.ramREN, bus.err} !== 2'b00) begin
         n_fail++;
         $display("FAIL withdraw_idle: ren err=%b expected 00", {bus.ramREN, bus.err});
      end
      @(negedge clk);
      n_checks++;
      if ({bus.ramREN, bus.ramaddr} !== {1'b1, 32'hA00}) begin
         n_fail++;
         $display("FAIL withdraw_next: ren=%b addr=%h expected 1 00000a00", bus.ramREN, bus.ramaddr);
      end
      wait_done(1'b0, 10, cyc);
      n_checks++;
      if (cyc != 4) begin
         n_fail++;
         $display("FAIL withdraw_ilat: %0d expected 4", cyc);
      end
      tick;
      bus.iREN = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_icache_read;
      test_contention;
      test_starvation;
      test_timeout;
      test_error;
      test_mid_reset;
      test_withdraw;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the cache pair and the RAM model/controller.
- Registered grant FSM; dcache has priority, bounded by an anti-starvation counter for the icache.
- Returns per-requester wait/load and flags accesses that time out or report an error.

Parameters:
- STARVE_LIMIT, 4, consecutive dcache grants allowed while iREN is pending before the icache is forced in.
- TIMEOUT, 64, max cycles a granted access may wait for ramstate==ACCESS before abort.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- iREN  in  1  icache read request
- iaddr  in  32  icache address (word_t)
- iwait  out  1  icache stall; 0 for exactly the completion cycle
- iload  out  32  icache read data, valid when iwait==0
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache address
- dstore  in  32  dcache write data
- dwait  out  1  dcache stall; 0 for exactly the completion cycle
- dload  out  32  dcache read data, valid when dwait==0
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- err  out  1  one-cycle pulse on access abort (ERROR or timeout)

Behaviour:
- Reset:
  - state=IDLE; starve_cnt=0; tmo_cnt=0.
  - iwait=dwait=1; ramREN=ramWEN=0; ramaddr=ramstore=0; err=0.
  - iload/dload are combinational pass-through of ramload.
- States: IDLE, DACC, IACC.
- IDLE: no RAM enables asserted.
  - Grant evaluated on registered state, taking effect next cycle (1-cycle grant latency).
  - dreq=dREN|dWEN.
  - dreq && !(iREN && starve_cnt==STARVE_LIMIT) -> DACC.
  - else iREN -> IACC.
  - else stay in IDLE.
- DACC:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore (combinational from dcache).
  - dREN&dWEN both high: write wins (ramREN=0).
- IACC: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
- Completion (ramstate==ACCESS in DACC/IACC):
  - Granted wait=0 that cycle; other wait stays 1.
  - Next state IDLE (one idle bubble between back-to-back accesses).
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on DACC completion while iREN==1.
  - Clears on IACC completion or when iREN==0 in IDLE.
- Withdrawal: granted requester drops its enable mid-access -> next state IDLE; no wait drop; no err; tmo_cnt cleared.
- ERROR or timeout:
  - ramstate==ERROR, or tmo_cnt reaches TIMEOUT-1 without ACCESS -> abort to IDLE.
  - err pulses 1 cycle; wait stays 1; requester retried by normal arbitration.
- tmo_cnt: counts in DACC/IACC and clears on every state change. TIMEOUT=1 means abort on the first non-ACCESS cycle.
- Simultaneous ACCESS and withdrawal in the same cycle: completion takes effect (wait drops).
- RST mid-access: state and counters return to reset values next edge; RAM enables drop immediately after the edge.

Decomposition:
- cpu_types_pkg: word_t, ramstate_t, new arb_state_t enum {IDLE, DACC, IACC}.
- Optional sub-module: arb_timeout_counter (tmo_cnt plus compare, clear/enable inputs, expire output).
- All other logic lives in mem_arbiter.

Test Plan:
- Reset, then idle: RST=1 for 2 cycles -> iwait=dwait=1, ramREN=ramWEN=0, err=0.
- Single icache read:
  - Stimulus: iREN=1, iaddr=0x100; RAM returns ACCESS on 3rd cycle of IACC, ramload=0xDEADBEEF.
  - Required: ramREN=1, ramaddr=0x100 from cycle after request; iwait=0, iload=0xDEADBEEF on that cycle only.
- Contention:
  - Stimulus: iREN=1 and dWEN=1, daddr=0x200, dstore=0x12345678 asserted together.
  - Required: DACC first with ramWEN=1, ramstore=0x12345678; IACC after one IDLE bubble.
- Starvation: dREN and iREN held high, 1-cycle RAM latency, STARVE_LIMIT=4 -> exactly 4 dwait completions, then an iwait completion.
- Timeout/error:
  - Stimulus: ramstate held BUSY with TIMEOUT=8.
  - Required: err pulse after 8 cycles in DACC, dwait never 0, re-grant follows.
  - Stimulus: ramstate=ERROR -> immediate err pulse.
- Mid-access events:
  - RST asserted in IACC -> next cycle state IDLE, ramREN=0.
  - dREN dropped in DACC -> IDLE, no err, no dwait drop.
